fft_bitrev_reorder: RTL
=======================

// Module: fft_bitrev_reorder
// PURPOSE
//  Output reorder buffer placed after the last radix-2 stage of the 2^bram_addr_len-point streaming FFT.
//  Stages emit results in bit-reversed index order; this block restores natural order (X[0], X[1], ...).
//  Ping-pong BRAM: one bank is written while the other is read. Frames pass through one sample per cycle.
//  Data word: {real, imag}, each a float_len-bit float, carried unmodified (no arithmetic).
// PARAMETERS
//  float_len      32  bits per real/imag float; data word = 2*float_len bits
//  bram_addr_len  13  log2(points per frame); N = 2^bram_addr_len = 8192
// PORTS
//  clk             in   1              single clock, rising edge
//  rst             in   1              asynchronous, active-high reset
//  data_in         in   2*float_len    sample from last radix stage, bit-reversed frame order
//  data_in_valid   in   1              data_in is captured on every clk edge where this is high
//  data_out        out  2*float_len    natural-order sample; 0 when data_out_valid is low
//  data_out_valid  out  1              data_out holds a valid sample
//  data_out_sof    out  1              high together with data_out_valid on X[0] of each frame
// BEHAVIOUR
//  Reset (async, any time): all outputs 0; wr_cnt=0, wr_bank=0, both bank_full=0, reader FSM=IDLE.
//   Any partial frame and any buffered frame is discarded. No output appears until a new full frame is received.
//   BRAM contents are not cleared.
//  Write side: on each edge with data_in_valid=1, write data_in to bank wr_bank at address wr_cnt. Then wr_cnt++.
//   data_in_valid may drop mid-frame; wr_cnt holds while it is low.
//   When a write has wr_cnt=N-1: wr_cnt wraps to 0, bank_full[wr_bank] is set, and wr_bank toggles (same edge).
//  Read FSM, states IDLE / READ:
//   IDLE -> READ when bank_full[rd_bank]=1. rd_cnt=0.
//   READ: each cycle, issue BRAM read of bank rd_bank at address bitrev(rd_cnt) over bram_addr_len bits.
//    Then rd_cnt++.
//   On issuing rd_cnt=N-1: clear bank_full[rd_bank] and toggle rd_bank.
//    If bank_full of the new rd_bank is already 1, or is set on the same edge, stay in READ with rd_cnt=0
//     (no bubble). Otherwise go to IDLE.
//  Output pipeline: 1-cycle BRAM read, then 1 output register.
//   data_out/valid/sof are registered and asserted 2 cycles after the read issue.
//  Latency: the edge capturing a frame's last input sample is E.
//   The first output (X[0], sof=1) is valid after edge E+3, when the reader is idle.
//   A frame's N outputs are valid on N consecutive cycles, with no gaps.
//  Gapless input frames produce gapless output with no bubble between frames.
//  Writing a bank never overtakes the read of the same bank: input rate <= 1/cycle and the read drains N samples in N cycles.
//  Simultaneous set and clear of bank_full on different banks in the same cycle: both take effect.
//  Addresses wrap modulo N. No overflow or underflow flags are needed under the 1-sample/cycle input limit.
// TESTING
//  1. Assert rst mid-run with random inputs.
//     -> data_out=0, data_out_valid=0, data_out_sof=0 immediately (async), and they stay 0 after release.
//  2. bram_addr_len=3, gapless data_in=k, k=0..7.
//     -> valid for 8 cycles starting 3 edges after the k=7 capture.
//     -> data_out = 0,4,2,6,1,5,3,7; sof=1 on the first output only.
//  3. bram_addr_len=3, data_in_valid high every other cycle, data_in=k.
//     -> same order 0,4,2,6,1,5,3,7; first valid 3 edges after the last capture; 8 contiguous outputs.
//  4. bram_addr_len=3, 16 gapless inputs k=0..15.
//     -> 16 contiguous valid outputs 0,4,2,6,1,5,3,7,8,12,10,14,9,13,11,15; sof on outputs 0 and 8.
//  5. bram_addr_len=3: 5 samples, then pulse rst, then a full frame data_in=100+k.
//     -> only 100,104,102,106,101,105,103,107 are output; no stale data.
//  6. Default params, 3 frames of random data with random valid gaps.
//     -> out[k] = in[bitrev13(k)] per frame; 8192 contiguous valids per frame.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Natural-order reorder buffer for the streaming FFT output.
// Ping-pong banks: one is filled in bit-reversed order while the other is drained in natural order.
module fft_bitrev_reorder #(
   parameter int unsigned float_len     = 32,
   parameter int unsigned bram_addr_len = 13
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [2*float_len-1:0]   data_in,
   input  logic                     data_in_valid,
   output logic [2*float_len-1:0]   data_out,
   output logic                     data_out_valid,
   output logic                     data_out_sof
);

   localparam int unsigned DW    = 2 * float_len;
   localparam int unsigned AW    = bram_addr_len;
   localparam int unsigned DEPTH = 2 ** (AW + 1);
   localparam logic [AW-1:0] LAST = '1;

   typedef enum logic {ST_IDLE, ST_READ} state_t;

   state_t            r_state;
   logic [AW-1:0]     r_wr_cnt;
   logic              r_wr_bank;
   logic [1:0]        r_bank_full;
   logic [AW-1:0]     r_rd_cnt;
   logic              r_rd_bank;
   logic              r_rd_valid;
   logic              r_rd_sof;
   logic [DW-1:0]     r_rd_data;
   logic [DW-1:0]     r_mem [DEPTH];

   logic              w_wr_last;
   logic              w_rd_en;
   logic              w_rd_last;
   logic              w_next_full;
   logic [1:0]        w_full_nxt;
   logic [AW:0]       w_wr_addr;
   logic [AW:0]       w_rd_addr;

   function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] a);
      logic [AW-1:0] v;
      for (int unsigned i = 0; i < AW; i++) v[i] = a[AW-1-i];
      return v;
   endfunction

   assign w_wr_last   = data_in_valid && (r_wr_cnt == LAST);
   assign w_rd_en     = (r_state == ST_READ);
   assign w_rd_last   = w_rd_en && (r_rd_cnt == LAST);
   assign w_wr_addr   = {r_wr_bank, r_wr_cnt};
   assign w_rd_addr   = {r_rd_bank, f_bitrev(r_rd_cnt)};
   // The other bank counts as ready if it is full already or completes on this edge.
   assign w_next_full = r_bank_full[~r_rd_bank] || (w_wr_last && (r_wr_bank != r_rd_bank));

   always_comb begin
      w_full_nxt = r_bank_full;
      if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
      if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
   end

   // Sample storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (data_in_valid) r_mem[w_wr_addr] <= data_in;
      if (w_rd_en)       r_rd_data        <= r_mem[w_rd_addr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_wr_cnt       <= '0;
         r_wr_bank      <= 1'b0;
         r_bank_full    <= '0;
         r_rd_cnt       <= '0;
         r_rd_bank      <= 1'b0;
         r_rd_valid     <= 1'b0;
         r_rd_sof       <= 1'b0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         data_out_sof   <= 1'b0;
      end else begin
         if (data_in_valid) begin
            r_wr_cnt <= r_wr_cnt + AW'(1);
            if (w_wr_last) r_wr_bank <= ~r_wr_bank;
         end
         r_bank_full <= w_full_nxt;

         case (r_state)
            ST_IDLE: begin
               if (r_bank_full[r_rd_bank]) begin
                  r_state  <= ST_READ;
                  r_rd_cnt <= '0;
               end
            end
            ST_READ: begin
               r_rd_cnt <= r_rd_cnt + AW'(1);
               if (w_rd_last) begin
                  r_rd_bank <= ~r_rd_bank;
                  if (!w_next_full) r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         r_rd_valid     <= w_rd_en;
         r_rd_sof       <= w_rd_en && (r_rd_cnt == '0);
         data_out       <= r_rd_valid ? r_rd_data : '0;
         data_out_valid <= r_rd_valid;
         data_out_sof   <= r_rd_sof;
      end
   end

endmodule
